cfg_tile_receiver: RTL and testbench
====================================

CFG_TILE_RECEIVER -- requirements
Module: cfg_tile_receiver

Interface
REQ-001 SHALL have parameter TILE_ID, default 16'h0015: tile address this block answers to, matched against config_addr_in[15:0].
REQ-002 SHALL have parameter NUM_REGS, default 8 (range 1..16): number of 32-bit config registers held.
REQ-003 SHALL have parameter IDLE_LIMIT, default 4: consecutive idle cycles that end configuration.
REQ-004 clk_in  input  1  sole clock, rising edge.
REQ-005 reset_in  input  1  asynchronous, active-low reset.
REQ-006 config_addr_in  input  32  [15:0] tile, [23:16] feature (ignored), [31:24] register index; all-zero = idle/no-op.
REQ-007 config_data_in  input  32  write data.
REQ-008 config_read_in  input  1  1 = read request, 0 = write, qualified by a nonzero address.
REQ-009 cfg_reg_out  output  32*NUM_REGS  register i on bits [32i+31:32i].
REQ-010 read_data_out  output  32  readback data.
REQ-011 read_valid_out  output  1  one-cycle strobe qualifying read_data_out.
REQ-012 config_done_out  output  1  configuration complete.
REQ-013 write_count_out  output  16  accepted writes since reset.
REQ-014 err_out  output  1  sticky out-of-range access flag.

Function
REQ-015 SHALL register config_addr_in, config_data_in and config_read_in into a stage-1 register on every rising edge, with no stall.
REQ-016 A stage-1 entry SHALL be a hit when addr != 0, addr[15:0] == TILE_ID and addr[31:24] < NUM_REGS.
REQ-017 A write hit SHALL update register addr[31:24] on the next edge, so cfg_reg_out shows new data 2 edges after the input is presented.
REQ-018 A read hit SHALL drive read_data_out = register value and read_valid_out = 1 for exactly one cycle, 2 edges after the input is presented. read_data_out SHALL hold its last value otherwise.
REQ-019 A read and a write to the same register in back-to-back cycles SHALL return the pre-write value for the read only if the read is presented first; a read presented after the write SHALL return the new value.
REQ-020 A nonzero address with a matching tile but addr[31:24] >= NUM_REGS SHALL set err_out and perform no write or read strobe. err_out SHALL remain set until reset.
REQ-021 Addresses for other tiles SHALL be ignored, except for FSM activity tracking.
REQ-022 write_count_out SHALL increment on each write hit and saturate at 16'hFFFF.
REQ-023 FSM states:
- IDLE (reset state).
- CONFIG: entered from IDLE on any stage-1 nonzero address, any tile.
- DONE: entered from CONFIG after IDLE_LIMIT consecutive stage-1 zero addresses.
REQ-024 Any nonzero address in DONE SHALL return the FSM to CONFIG, clear config_done_out on the same edge, and be processed normally.
REQ-025 The idle counter SHALL reset to 0 on any nonzero address, and SHALL saturate at IDLE_LIMIT.
REQ-026 config_done_out SHALL be 1 exactly while in DONE, registered, and never set from IDLE.

Reset
REQ-027 While reset_in = 0, all of the following SHALL clear immediately, regardless of clk_in: stage-1, all registers (0), read_data_out (0), read_valid_out (0), config_done_out (0), write_count_out (0), err_out (0), FSM = IDLE, idle counter = 0.
REQ-028 An in-flight stage-1 write SHALL be discarded when reset asserts mid-operation.
REQ-029 After release, the first rising edge SHALL sample inputs normally.

Verification
REQ-030 Write 0x0300_0015 / 0xDEADBEEF at edge N -> cfg_reg_out[127:96] = 0xDEADBEEF after edge N+1; write_count_out = 1.
REQ-031 Write reg 2 = 0x1234, then read reg 2 next cycle -> read_valid_out pulses once, read_data_out = 0x1234.
REQ-032 Write 0x0900_0015 (index 9, NUM_REGS = 8) -> err_out = 1 and stays 1; no register changes; write_count_out unchanged.
REQ-033 Address 0x0000_0016 (other tile) -> no register change; FSM leaves IDLE. Then 4 zero-address cycles -> config_done_out = 1; 3 zero-address cycles only -> still 0.
REQ-034 In DONE, write to reg 0 -> config_done_out = 0 on the same edge the write is staged; reg 0 is updated the following edge.
REQ-035 reset_in low between clock edges while a write is staged -> all outputs 0 immediately; the staged write never appears after release.

Source files
------------

// File: rtl/cfg_tile_receiver.sv
// ---------------------------------------------------------------------------
// cfg_tile_receiver
//
// Purpose: receives a stream of configuration accesses, answers only those
// addressed to this tile, holds NUM_REGS 32-bit configuration registers,
// returns read data with a one-cycle strobe, counts accepted writes, flags
// out-of-range accesses, and reports "configuration done" once the stream
// has gone quiet for IDLE_LIMIT consecutive cycles.
//
// Ports:
//   clk_in           in   1             sole clock, rising edge
//   reset_in         in   1             asynchronous active-low reset
//   config_addr_in   in   32            [15:0] tile, [23:16] feature (unused),
//                                       [31:24] register index, 0 = idle
//   config_data_in   in   32            write data
//   config_read_in   in   1             1 = read, 0 = write
//   cfg_reg_out      out  32*NUM_REGS   register i on bits [32i+31:32i]
//   read_data_out    out  32            readback data (holds between reads)
//   read_valid_out   out  1             one-cycle strobe for read_data_out
//   config_done_out  out  1             high while the FSM is in DONE
//   write_count_out  out  16            accepted writes, saturating
//   err_out          out  1             sticky out-of-range access flag
// ---------------------------------------------------------------------------
module cfg_tile_receiver #(
  parameter logic [15:0] TILE_ID    = 16'h0015,
  parameter int          NUM_REGS   = 8,
  parameter int          IDLE_LIMIT = 4
) (
  input  logic                     clk_in,
  input  logic                     reset_in,
  input  logic [31:0]              config_addr_in,
  input  logic [31:0]              config_data_in,
  input  logic                     config_read_in,
  output logic [32*NUM_REGS-1:0]   cfg_reg_out,
  output logic [31:0]              read_data_out,
  output logic                     read_valid_out,
  output logic                     config_done_out,
  output logic [15:0]              write_count_out,
  output logic                     err_out
);

  localparam int                IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int                IDLE_W     = $clog2(IDLE_LIMIT + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX   = IDLE_W'(IDLE_LIMIT);
  localparam logic [7:0]        NUM_REGS_B = 8'(NUM_REGS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONFIG = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Stage-1 capture of the incoming access
  logic [31:0]       s1_addr_q;
  logic [31:0]       s1_data_q;
  logic              s1_read_q;

  // Architectural state
  logic [31:0]       regs_q [NUM_REGS];
  logic [31:0]       regs_d [NUM_REGS];
  logic [31:0]       read_data_q, read_data_d;
  logic              read_valid_q, read_valid_d;
  logic [15:0]       wr_cnt_q, wr_cnt_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  state_e            state_q, state_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;

  // Decode of the staged access
  logic              s1_nonzero_s;
  logic              in_nonzero_s;
  logic              tile_match_s;
  logic [7:0]        idx_s;
  logic [IDX_W-1:0]  idx_sel_s;
  logic              idx_ok_s;
  logic              wr_hit_s;
  logic              rd_hit_s;
  logic              oor_s;

  // Decode the stage-1 entry into hit / out-of-range qualifiers
  always_comb begin
    s1_nonzero_s = (s1_addr_q != 32'h0000_0000);
    in_nonzero_s = (config_addr_in != 32'h0000_0000);
    tile_match_s = s1_nonzero_s && (s1_addr_q[15:0] == TILE_ID);
    idx_s        = s1_addr_q[31:24];
    idx_sel_s    = idx_s[IDX_W-1:0];
    idx_ok_s     = (idx_s < NUM_REGS_B);
    wr_hit_s     = tile_match_s && idx_ok_s && !s1_read_q;
    rd_hit_s     = tile_match_s && idx_ok_s && s1_read_q;
    oor_s        = tile_match_s && !idx_ok_s;
  end

  // Stage-1 register: samples every edge, never stalls; reset drops any staged access
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      s1_addr_q <= 32'h0000_0000;
      s1_data_q <= 32'h0000_0000;
      s1_read_q <= 1'b0;
    end else begin
      s1_addr_q <= config_addr_in;
      s1_data_q <= config_data_in;
      s1_read_q <= config_read_in;
    end
  end

  // Next-state for register file, read port, write counter and error flag.
  // Reads use the current register contents, so a read staged one cycle
  // ahead of a write sees the old value and one staged behind sees the new.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_hit_s && (idx_s == 8'(i))) begin
        regs_d[i] = s1_data_q;
      end else begin
        regs_d[i] = regs_q[i];
      end
    end

    read_valid_d = rd_hit_s;
    if (rd_hit_s) begin
      read_data_d = regs_q[idx_sel_s];
    end else begin
      read_data_d = read_data_q;
    end

    if (wr_hit_s && (wr_cnt_q != 16'hFFFF)) begin
      wr_cnt_d = wr_cnt_q + 16'd1;
    end else begin
      wr_cnt_d = wr_cnt_q;
    end

    err_d = err_q | oor_s;
  end

  // Activity FSM next-state. Leaving DONE reacts to the raw input so the
  // done flag drops on the same edge the new access is staged; entering
  // DONE is held off when an access is being staged on that very edge.
  always_comb begin
    state_d = state_q;

    if (s1_nonzero_s) begin
      idle_cnt_d = {IDLE_W{1'b0}};
    end else if (idle_cnt_q != IDLE_MAX) begin
      idle_cnt_d = idle_cnt_q + IDLE_W'(1);
    end else begin
      idle_cnt_d = idle_cnt_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (s1_nonzero_s) begin
          state_d = ST_CONFIG;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CONFIG: begin
        if (!s1_nonzero_s && (idle_cnt_d == IDLE_MAX) && !in_nonzero_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_CONFIG;
        end
      end
      ST_DONE: begin
        if (in_nonzero_s || s1_nonzero_s) begin
          state_d    = ST_CONFIG;
          idle_cnt_d = {IDLE_W{1'b0}};
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        idle_cnt_d = {IDLE_W{1'b0}};
      end
    endcase

    done_d = (state_d == ST_DONE);
  end

  // State registers for the register file, outputs and FSM
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= 32'h0000_0000;
      end
      read_data_q  <= 32'h0000_0000;
      read_valid_q <= 1'b0;
      wr_cnt_q     <= 16'h0000;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      state_q      <= ST_IDLE;
      idle_cnt_q   <= {IDLE_W{1'b0}};
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      wr_cnt_q     <= wr_cnt_d;
      err_q        <= err_d;
      done_q       <= done_d;
      state_q      <= state_d;
      idle_cnt_q   <= idle_cnt_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_pack
    assign cfg_reg_out[32*g +: 32] = regs_q[g];
  end

  assign read_data_out   = read_data_q;
  assign read_valid_out  = read_valid_q;
  assign config_done_out = done_q;
  assign write_count_out = wr_cnt_q;
  assign err_out         = err_q;

endmodule

// File: tb/tb_cfg_tile_receiver.sv
// Self-checking bench for cfg_tile_receiver (default parameters).
// Read expectations are queued when a read is presented and popped when
// read_valid_out fires; register contents come from a bench-side model.
module tb_cfg_tile_receiver;

  localparam int N = 8;

  logic             clk_in;
  logic             reset_in;
  logic [31:0]      config_addr_in;
  logic [31:0]      config_data_in;
  logic             config_read_in;
  logic [32*N-1:0]  cfg_reg_out;
  logic [31:0]      read_data_out;
  logic             read_valid_out;
  logic             config_done_out;
  logic [15:0]      write_count_out;
  logic             err_out;

  cfg_tile_receiver dut (
    .clk_in          (clk_in),
    .reset_in        (reset_in),
    .config_addr_in  (config_addr_in),
    .config_data_in  (config_data_in),
    .config_read_in  (config_read_in),
    .cfg_reg_out     (cfg_reg_out),
    .read_data_out   (read_data_out),
    .read_valid_out  (read_valid_out),
    .config_done_out (config_done_out),
    .write_count_out (write_count_out),
    .err_out         (err_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] data;
    int          due;
  } rd_exp_t;

  rd_exp_t     exp_q[$];
  logic [31:0] m_regs [N];
  logic [15:0] m_wc;
  logic        m_err;
  int          cyc;
  int          checks;
  int          errors;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: present an access, let the edge pass, check the read
  // port, then update the model in presentation order.
  task automatic step(input logic [31:0] a, input logic [31:0] d, input logic r);
    logic [7:0] idx;
    @(negedge clk_in);
    config_addr_in = a;
    config_data_in = d;
    config_read_in = r;
    @(posedge clk_in);
    #1;
    cyc++;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      check_val("rd_valid", {31'd0, read_valid_out}, 32'd1);
      check_val("rd_data", read_data_out, exp_q[0].data);
      void'(exp_q.pop_front());
    end else begin
      check_val("rd_quiet", {31'd0, read_valid_out}, 32'd0);
    end
    idx = a[31:24];
    if (a != 32'd0 && a[15:0] == 16'h0015) begin
      if (idx < 8'd8) begin
        if (r) begin
          exp_q.push_back('{m_regs[idx[2:0]], cyc + 1});
        end else begin
          m_regs[idx[2:0]] = d;
          if (m_wc != 16'hFFFF) m_wc = m_wc + 16'd1;
        end
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(32'd0, 32'd0, 1'b0);
  endtask

  task automatic check_state(input string tag);
    for (int i = 0; i < N; i++)
      check_val($sformatf("%s_reg%0d", tag, i), cfg_reg_out[32*i +: 32], m_regs[i]);
    check_val({tag, "_wcnt"}, {16'd0, write_count_out}, {16'd0, m_wc});
    check_val({tag, "_err"}, {31'd0, err_out}, {31'd0, m_err});
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_cfg"}, {31'd0, |cfg_reg_out}, 32'd0);
    check_val({tag, "_rdata"}, read_data_out, 32'd0);
    check_val({tag, "_rvalid"}, {31'd0, read_valid_out}, 32'd0);
    check_val({tag, "_done"}, {31'd0, config_done_out}, 32'd0);
    check_val({tag, "_wcnt"}, {16'd0, write_count_out}, 32'd0);
    check_val({tag, "_err"}, {31'd0, err_out}, 32'd0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_regs[i] = 32'd0;
    m_wc  = 16'd0;
    m_err = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    model_reset();
    reset_in       = 1'b0;
    config_addr_in = 32'd0;
    config_data_in = 32'd0;
    config_read_in = 1'b0;

    // Reset state
    #3;
    check_all_zero("reset");
    #9;
    reset_in = 1'b1;

    // Other tile: no register change, FSM leaves IDLE; 3 idles then activity -> not done
    step(32'h0000_0016, 32'hFFFF_FFFF, 1'b0);
    idle(3);
    step(32'h0000_0016, 32'h0000_0000, 1'b1);
    check_val("done_after3", {31'd0, config_done_out}, 32'd0);
    check_state("othertile");
    // Four idle accesses staged; done appears once the fourth has been processed
    idle(4);
    check_val("done_pre", {31'd0, config_done_out}, 32'd0);
    idle(1);
    check_val("done_set", {31'd0, config_done_out}, 32'd1);
    idle(2);
    check_val("done_hold", {31'd0, config_done_out}, 32'd1);

    // Write in DONE: done drops when staged, register lands next edge
    step(32'h0000_0015, 32'hA5A5_0001, 1'b0);
    check_val("done_clr", {31'd0, config_done_out}, 32'd0);
    check_val("reg0_pending", cfg_reg_out[31:0], 32'd0);
    idle(1);
    check_val("reg0_landed", cfg_reg_out[31:0], 32'hA5A5_0001);

    // Basic write to register 3
    step(32'h0300_0015, 32'hDEAD_BEEF, 1'b0);
    check_val("reg3_pending", cfg_reg_out[127:96], 32'd0);
    idle(1);
    check_val("reg3_landed", cfg_reg_out[127:96], 32'hDEAD_BEEF);
    check_state("wr3");

    // Write then read back-to-back, read-before-write, read-after-write
    step(32'h0200_0015, 32'h0000_1234, 1'b0);
    step(32'h0200_0015, 32'd0, 1'b1);
    step(32'h0200_0015, 32'd0, 1'b1);
    step(32'h0200_0015, 32'h0000_5678, 1'b0);
    step(32'h0200_0015, 32'd0, 1'b1);
    step(32'h0300_0015, 32'd0, 1'b1);
    idle(3);
    check_val("rd_hold", read_data_out, 32'hDEAD_BEEF);

    // Write loop over all registers with distinct patterns, then read all back
    for (int i = 0; i < N; i++)
      step({8'(i), 8'h00, 16'h0015}, 32'h1111_1111 * (i + 1) ^ 32'h0F0F_0000, 1'b0);
    for (int i = N - 1; i >= 0; i--)
      step({8'(i), 8'h7E, 16'h0015}, 32'd0, 1'b1);
    idle(2);
    check_state("sweep");

    // Out-of-range index: sticky error, no write, no read strobe
    step(32'h0900_0015, 32'hBAD0_BAD0, 1'b0);
    step(32'h0800_0015, 32'd0, 1'b1);
    idle(2);
    check_state("oor");
    step(32'h0100_0015, 32'h0000_0042, 1'b0);
    idle(2);
    check_state("err_sticky");

    // Asynchronous reset between edges while a write is staged
    step(32'h0500_0015, 32'hCAFE_F00D, 1'b0);
    #2;
    reset_in = 1'b0;
    #1;
    check_all_zero("midreset");
    model_reset();
    @(posedge clk_in);
    #2;
    reset_in = 1'b1;
    idle(2);
    check_state("postreset");

    // First edge after release samples normally
    step(32'h0100_0015, 32'h0000_0011, 1'b0);
    idle(1);
    check_state("firstedge");
    check_val("queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
